seq_detector_param: RTL and testbench

Parametrised, runtime-programmable serial bit-pattern detector (Mealy). It compares the most recent PAT_W bits of a qualified serial stream against a loaded pattern, and each matching bit raises `detected` in the same cycle. Overlapping or non-overlapping matching is selected at run time. A saturating match counter and the history fill level are exposed for monitoring. It is the general replacement for the fixed 4-bit "1011" detectors in the sequence-detector family.

---
 rtl/seq_detector_param.sv | 88 ++++++++
 tb/tb_seq_detector_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (Mealy), overlap/non-overlap.
// Ports: clk, rst (sync, active-high), in_valid/in stream, cfg_load/
// cfg_pattern/cfg_overlap config, count_clr; outputs detected (comb),
// match_count (saturating), count_sat (sticky), fill_level.
module seq_detector_param #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(4'b1011),
  parameter logic             RST_OVERLAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in,
  input  logic                     cfg_load,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic                     cfg_overlap,
  input  logic                     count_clr,
  output logic                     detected,
  output logic [CNT_W-1:0]         match_count,
  output logic                     count_sat,
  output logic [$clog2(PAT_W)-1:0] fill_level
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] cand;
  logic             take;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_base;
  logic             sat_next;

  // A load cycle discards the incoming bit entirely.
  assign take = in_valid & ~cfg_load;
  assign cand = {hist, in};
  assign detected = take & (fill == FULL) & (cand == pat_q);
  assign fill_level = fill;

  // Clear acts before the increment so clear+match leaves a count of 1.
  always_comb begin
    cnt_base = count_clr ? '0 : match_count;
    sat_base = count_clr ? 1'b0 : count_sat;
    cnt_next = cnt_base;
    if (detected && cnt_base != CMAX)
      cnt_next = cnt_base + CNT_W'(1);
    sat_next = sat_base | (cnt_next == CMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q       <= RST_PATTERN;
      ovl_q       <= RST_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (cfg_load) begin
      pat_q       <= cfg_pattern;
      ovl_q       <= cfg_overlap;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match_count <= cnt_next;
      count_sat   <= sat_next;
      if (take) begin
        // Non-overlap: matched bits are consumed, history restarts.
        if (detected && !ovl_q) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= cand[PAT_W-2:0];
          if (fill != FULL)
            fill <= fill + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: default instance plus a
// 2-bit-counter all-ones instance for saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic       cfg_overlap = 1'b0;
  logic       count_clr = 1'b0;

  logic       detected;
  logic [7:0] match_count;
  logic       count_sat;
  logic [1:0] fill_level;

  logic       s_det;
  logic [1:0] s_cnt;
  logic       s_sat;
  logic [1:0] s_fill;

  int   n_pass = 0;
  int   n_tot  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_detector_param d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .detected(detected), .match_count(match_count),
    .count_sat(count_sat), .fill_level(fill_level)
  );

  seq_detector_param #(
    .PAT_W(4), .CNT_W(2), .RST_PATTERN(4'b1111), .RST_OVERLAP(1'b1)
  ) s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .detected(s_det), .match_count(s_cnt),
    .count_sat(s_sat), .fill_level(s_fill)
  );

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] p, input logic o);
    in_valid = 1'b0;
    cfg_load = 1'b1; cfg_pattern = p; cfg_overlap = o;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tot++;
    if ({detected, match_count, count_sat, fill_level} !== 12'h0)
      $display("FAIL reset_outs got det=%b cnt=%0d sat=%b fill=%0d want 0",
               detected, match_count, count_sat, fill_level);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_overlap();
    logic [6:0] st = 7'b1011011;
    logic [6:0] ex = 7'b0001001;
    logic e;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      in_valid = 1'b1; in = st[i];
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tot++;
      if (detected !== e)
        $display("FAIL ovl_det bit%0d got %b want %b", 7 - i, detected, e);
      else n_pass++;
      @(posedge clk); #1;
      if (i == 4) begin
        n_tot++;
        if (fill_level !== 2'd3)
          $display("FAIL ovl_fill got %0d want 3", fill_level);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_tot++;
    if (match_count !== 8'd2)
      $display("FAIL ovl_count got %0d want 2", match_count);
    else n_pass++;
  endtask

  task automatic test_nonoverlap();
    logic [6:0] st = 7'b1011011;
    logic [6:0] ex = 7'b0001000;
    logic e;
    do_load(4'b1011, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      in_valid = 1'b1; in = st[i];
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tot++;
      if (detected !== e)
        $display("FAIL novl_det bit%0d got %b want %b", 7 - i, detected, e);
      else n_pass++;
      @(posedge clk); #1;
      if (i == 3) begin
        n_tot++;
        if (fill_level !== 2'd0)
          $display("FAIL novl_fill got %0d want 0", fill_level);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_tot++;
    if (match_count !== 8'd1)
      $display("FAIL novl_count got %0d want 1", match_count);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [3:0] st = 4'b1011;
    logic e;
    do_load(4'b1011, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      if (i != 3) begin
        for (int g = 0; g < 3; g++) begin
          in_valid = 1'b0; in = 1'b1;
          exp_q.push_back(1'b0);
          @(negedge clk);
          e = exp_q.pop_front();
          n_tot++;
          if (detected !== e)
            $display("FAIL gap_det got %b want %b", detected, e);
          else n_pass++;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1; in = st[i];
      exp_q.push_back(i == 0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tot++;
      if (detected !== e)
        $display("FAIL gap_bit_det bit%0d got %b want %b", 4 - i, detected, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reconfig();
    logic [7:0] st = 8'b1011_0110;
    logic [7:0] ex = 8'b0000_0001;
    logic e;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      in_valid = 1'b1; in = st[i];
      cfg_load = (i == 4);
      cfg_pattern = 4'b0110; cfg_overlap = 1'b1;
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tot++;
      if (detected !== e)
        $display("FAIL recfg_det step%0d got %b want %b", 8 - i, detected, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    cfg_load = 1'b0; in_valid = 1'b0;
    n_tot++;
    if (match_count !== 8'd1)
      $display("FAIL recfg_count got %0d want 1", match_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic e;
    int   ec;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in = 1'b1;
      exp_q.push_back(i >= 3);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tot++;
      if (s_det !== e)
        $display("FAIL sat_det bit%0d got %b want %b", i + 1, s_det, e);
      else n_pass++;
      @(posedge clk); #1;
      if (i >= 3) begin
        ec = (i - 2 > 3) ? 3 : i - 2;
        n_tot++;
        if (s_cnt !== 2'(ec) || s_sat !== (i >= 5))
          $display("FAIL sat_count bit%0d got cnt=%0d sat=%b want cnt=%0d sat=%b",
                   i + 1, s_cnt, s_sat, ec, (i >= 5));
        else n_pass++;
      end
    end
    count_clr = 1'b1;
    exp_q.push_back(1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    n_tot++;
    if (s_det !== e)
      $display("FAIL clr_det got %b want %b", s_det, e);
    else n_pass++;
    @(posedge clk); #1;
    count_clr = 1'b0; in_valid = 1'b0;
    n_tot++;
    if (s_cnt !== 2'd1 || s_sat !== 1'b0)
      $display("FAIL clr_count got cnt=%0d sat=%b want cnt=1 sat=0",
               s_cnt, s_sat);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] st = 4'b1011;
    logic e;
    do_reset();
    for (int i = 3; i >= 1; i--) begin
      in_valid = 1'b1; in = st[i];
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b1; in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tot++;
    if ({detected, match_count, count_sat, fill_level} !== 12'h0)
      $display("FAIL rstmid_outs got det=%b cnt=%0d sat=%b fill=%0d want 0",
               detected, match_count, count_sat, fill_level);
    else n_pass++;
    @(posedge clk); #1;
    for (int i = 3; i >= 0; i--) begin
      in_valid = 1'b1; in = st[i];
      exp_q.push_back(i == 0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tot++;
      if (detected !== e)
        $display("FAIL rstmid_det bit%0d got %b want %b", 4 - i, detected, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_pattern();
    logic [6:0] st = 7'b0000010;
    logic [6:0] ex = 7'b0001100;
    logic e;
    do_load(4'b0000, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      in_valid = 1'b1; in = st[i];
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tot++;
      if (detected !== e)
        $display("FAIL zero_det bit%0d got %b want %b", 7 - i, detected, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_tot++;
    if (match_count !== 8'd2)
      $display("FAIL zero_count got %0d want 2", match_count);
    else n_pass++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_reconfig();
    test_saturation();
    test_reset_mid();
    test_zero_pattern();
    if (exp_q.size() != 0) begin
      n_tot++;
      $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
